// File: rtl/down_counter_scheduler.sv
// down_counter_scheduler: one loadable down counter shared by NREQ timer clients.
// A round-robin arbiter picks an owner in IDLE. The owner's load value is latched
// at the grant edge and counted down to zero. The owner then gets a one-cycle done
// pulse, and the block returns to IDLE. The owner just served has lowest priority
// in the next arbitration.
module down_counter_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CNT   = 2'd2,
        DN    = 2'd3
    } state_t;

    state_t                       state;
    logic [NREQ-1:0][WIDTH-1:0]   data_arr;
    logic [WIDTH-1:0]             held;      // load value captured at the grant edge
    logic [IW-1:0]                last;      // index of the most recently served owner
    logic [IW-1:0]                gidx;      // index of the current owner
    logic                         pick_vld;
    logic [IW-1:0]                pick_idx;
    logic [IW-1:0]                cand;

    // Slice the flat load-value bus into one entry per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: the search runs from the farthest offset toward last+1, so
    // the closest set request after the last owner overwrites the earlier candidates.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign busy = (state != IDLE);

    // Service FSM with registered grant, done and count outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            count <= '0;
            held  <= '0;
            gidx  <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        held  <= data_arr[pick_idx];
                        gidx  <= pick_idx;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= held;
                    state <= CNT;
                end
                CNT: begin
                    // Stop at zero. The counter never wraps below it.
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        done  <= grant;
                        state <= DN;
                    end
                end
                DN: begin
                    done  <= '0;
                    grant <= '0;
                    last  <= gidx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_scheduler.sv
// Directed bench for down_counter_scheduler (NREQ=4, WIDTH=4), with hand-computed expectations.
module tb_down_counter_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    down_counter_scheduler #(.NREQ(4), .WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic [3:0] c);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".count"}, 32'(count), 32'(c));
    endtask

    // Run one full service. The caller has already driven req/req_data, and the
    // next edge is the grant edge E0. Done is expected after edge E0+d+2, and
    // grant is expected to clear at E0+d+3.
    task automatic svc(input string tag, input logic [3:0] g, input int d, input bit mutate);
        tick();
        chk_all({tag, ".e0"}, g, 4'b0, 1'b1, 4'd0);
        if (mutate) begin
            req      = 4'b0000;
            req_data = {4{4'd5}};
        end
        tick();
        chk_all({tag, ".load"}, g, 4'b0, 1'b1, 4'(d));
        for (int j = 1; j <= d; j++) begin
            tick();
            chk_all({tag, ".cnt"}, g, 4'b0, 1'b1, 4'(d - j));
        end
        tick();
        chk_all({tag, ".done"}, g, g, 1'b1, 4'd0);
        tick();
        chk_all({tag, ".clr"}, 4'b0, 4'b0, 1'b0, 4'd0);
    endtask

    initial begin
        // 1. reset and idle
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_hold", 4'b0, 4'b0, 1'b0, 4'd0);
        rst = 1'b0;
        tick();
        chk_all("idle0", 4'b0, 4'b0, 1'b0, 4'd0);
        repeat (3) tick();
        chk_all("idle3", 4'b0, 4'b0, 1'b0, 4'd0);

        // 2. single request, D=3
        req      = 4'b0001;
        req_data = 16'h0003;
        svc("single", 4'b0001, 3, 1'b0);
        req = 4'b0000;
        tick();
        chk_all("single_idle", 4'b0, 4'b0, 1'b0, 4'd0);

        // 3. fresh pointer, all four requesting: round-robin from requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req      = 4'b1111;
        req_data = 16'h4321;
        svc("rr0", 4'b0001, 1, 1'b0);
        svc("rr1", 4'b0010, 2, 1'b0);
        svc("rr2", 4'b0100, 3, 1'b0);
        svc("rr3", 4'b1000, 4, 1'b0);
        svc("rr4", 4'b0001, 1, 1'b0);
        req = 4'b0000;

        // 4. zero load value
        req      = 4'b0100;
        req_data = 16'h0000;
        svc("zero", 4'b0100, 0, 1'b0);
        req = 4'b0000;

        // 5. req dropped and data changed after grant; latched value 10 still runs
        req      = 4'b0010;
        req_data = 16'h00A0;
        svc("latch", 4'b0010, 10, 1'b1);

        // full-range count; pointer is at 1 so the search wraps to requester 0
        req      = 4'b0001;
        req_data = 16'h000F;
        svc("full", 4'b0001, 15, 1'b0);
        req = 4'b0000;

        // 6. reset mid-count: last=0 here, so only a pointer reset makes 0001 win below
        req      = 4'b1000;
        req_data = 16'h9000;
        tick();
        chk_all("abort_e0", 4'b1000, 4'b0, 1'b1, 4'd0);
        req = 4'b0000;
        repeat (4) tick();
        chk_all("abort_pre", 4'b1000, 4'b0, 1'b1, 4'd6);
        rst = 1'b1;
        #1;
        chk_all("abort_now", 4'b0, 4'b0, 1'b0, 4'd0);
        tick();
        chk_all("abort_hold", 4'b0, 4'b0, 1'b0, 4'd0);
        rst = 1'b0;
        tick();
        chk_all("abort_rel", 4'b0, 4'b0, 1'b0, 4'd0);
        req      = 4'b1001;
        req_data = 16'h1002;
        svc("post0", 4'b0001, 2, 1'b0);
        svc("post3", 4'b1000, 1, 1'b0);
        req = 4'b0000;
        tick();
        chk_all("final_idle", 4'b0, 4'b0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
